// File: rtl/param_sync_fifo.sv
// Parametrised single-clock show-ahead FIFO with valid/ready on both sides,
// almost-full flag and saturating drop counter. Define FIFO_ASSERT_EN to elaborate property checks.
module param_sync_fifo #(
   parameter int WIDTH     = 4,
   parameter int ADDR_W    = 3,
   parameter int AFULL_LVL = 6,
   parameter int DROP_W    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic [ADDR_W:0]   count,
   output logic              almost_full,
   output logic [DROP_W-1:0] drop_cnt
);

   localparam int                DEPTH     = 1 << ADDR_W;
   localparam logic [ADDR_W:0]   AFULL_CNT = (ADDR_W + 1)'(AFULL_LVL);
   localparam logic [DROP_W-1:0] DROP_MAX  = '1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [ADDR_W:0]  wr_ptr;
   logic [ADDR_W:0]  rd_ptr;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             drop;

   // Extra pointer MSB distinguishes full from empty when the address bits match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                  (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

   assign count       = wr_ptr - rd_ptr;
   assign in_ready    = !full;
   assign out_valid   = !empty;
   assign almost_full = (count >= AFULL_CNT);

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;
   assign drop = in_valid & !in_ready;

   assign out_data = mem[rd_ptr[ADDR_W-1:0]];

   // NOTE: storage has no reset; entries are only observable once a push has
   // written them, and leaving reset off lets the array map onto RAM.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[ADDR_W-1:0]] <= in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        drop_cnt <= '0;
      else if (drop && drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + 1'b1;
   end

`ifdef FIFO_ASSERT_EN
   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

   a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
      count <= DEPTH_CNT);
   a_not_full_empty: assert property (@(posedge clk) disable iff (!rst_n)
      !(full && empty));
   a_push_empty_valid: assert property (@(posedge clk) disable iff (!rst_n)
      (push && empty) |=> out_valid);
   a_drop_monotonic: assert property (@(posedge clk) disable iff (!rst_n)
      drop_cnt >= $past(drop_cnt));
   a_afull_match: assert property (@(posedge clk) disable iff (!rst_n)
      almost_full == (count >= AFULL_CNT));
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench for param_sync_fifo: default instance (a) and a narrow
// override instance (b), each compared against a queue-based reference model.
module tb_param_sync_fifo;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic       in_valid_a, in_ready_a, out_valid_a, out_ready_a, almost_full_a;
   logic [3:0] in_data_a, out_data_a, count_a, drop_cnt_a;

   logic       in_valid_b, in_ready_b, out_valid_b, out_ready_b, almost_full_b;
   logic [7:0] in_data_b, out_data_b;
   logic [2:0] count_b;
   logic [1:0] drop_cnt_b;

   param_sync_fifo dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
      .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
      .count(count_a), .almost_full(almost_full_a), .drop_cnt(drop_cnt_a)
   );

   param_sync_fifo #(.WIDTH(8), .ADDR_W(2), .AFULL_LVL(3), .DROP_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
      .count(count_b), .almost_full(almost_full_b), .drop_cnt(drop_cnt_b)
   );

   int vec_cnt = 0;
   int err_cnt = 0;

   // Reference model: queue holds the FIFO contents; exp_* collect model pops,
   // obs_* collect what the DUT actually handed over.
   logic [3:0] mq_a[$], obs_a[$], exp_a[$];
   logic [7:0] mq_b[$], obs_b[$], exp_b[$];
   int drops_a, drops_b;

   task automatic clear_model();
      mq_a.delete(); obs_a.delete(); exp_a.delete(); drops_a = 0;
      mq_b.delete(); obs_b.delete(); exp_b.delete(); drops_b = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid_a = 0; out_ready_a = 0; in_valid_b = 0; out_ready_b = 0;
      rst_n = 0;
      clear_model();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
   endtask

   // One cycle on instance a: apply inputs at the falling edge, record the
   // handover, advance the model, return at the next falling edge.
   task automatic drive_a(input logic iv, input logic [3:0] d, input logic ordy);
      bit can_push, can_pop;
      in_valid_a = iv; in_data_a = d; out_ready_a = ordy;
      #1;
      if (out_valid_a && ordy) obs_a.push_back(out_data_a);
      can_push = iv && (mq_a.size() < 8);
      can_pop  = ordy && (mq_a.size() > 0);
      if (iv && !(mq_a.size() < 8) && drops_a < 15) drops_a++;
      if (can_pop)  exp_a.push_back(mq_a.pop_front());
      if (can_push) mq_a.push_back(d);
      @(negedge clk);
   endtask

   task automatic drive_b(input logic iv, input logic [7:0] d, input logic ordy);
      bit can_push, can_pop;
      in_valid_b = iv; in_data_b = d; out_ready_b = ordy;
      #1;
      if (out_valid_b && ordy) obs_b.push_back(out_data_b);
      can_push = iv && (mq_b.size() < 4);
      can_pop  = ordy && (mq_b.size() > 0);
      if (iv && !(mq_b.size() < 4) && drops_b < 3) drops_b++;
      if (can_pop)  exp_b.push_back(mq_b.pop_front());
      if (can_push) mq_b.push_back(d);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 0;
      #2;
      vec_cnt++; if (count_a !== 4'd0)      begin err_cnt++; $display("FAIL reset_count_a: got %0d want 0", count_a); end
      vec_cnt++; if (out_valid_a !== 1'b0)  begin err_cnt++; $display("FAIL reset_out_valid_a: got %b want 0", out_valid_a); end
      vec_cnt++; if (in_ready_a !== 1'b1)   begin err_cnt++; $display("FAIL reset_in_ready_a: got %b want 1", in_ready_a); end
      vec_cnt++; if (almost_full_a !== 1'b0) begin err_cnt++; $display("FAIL reset_afull_a: got %b want 0", almost_full_a); end
      vec_cnt++; if (drop_cnt_a !== 4'd0)   begin err_cnt++; $display("FAIL reset_drop_a: got %0d want 0", drop_cnt_a); end
      vec_cnt++; if (count_b !== 3'd0)      begin err_cnt++; $display("FAIL reset_count_b: got %0d want 0", count_b); end
      vec_cnt++; if (out_valid_b !== 1'b0)  begin err_cnt++; $display("FAIL reset_out_valid_b: got %b want 0", out_valid_b); end
      vec_cnt++; if (in_ready_b !== 1'b1)   begin err_cnt++; $display("FAIL reset_in_ready_b: got %b want 1", in_ready_b); end
      vec_cnt++; if (drop_cnt_b !== 2'd0)   begin err_cnt++; $display("FAIL reset_drop_b: got %0d want 0", drop_cnt_b); end
      do_reset();
   endtask

   task automatic test_three_push();
      do_reset();
      in_valid_a = 1; in_data_a = 4'h1; out_ready_a = 0;
      #1;
      vec_cnt++; if (out_valid_a !== 1'b0) begin err_cnt++; $display("FAIL no_fall_through: got %b want 0", out_valid_a); end
      drive_a(1, 4'h1, 0);
      vec_cnt++; if (out_valid_a !== 1'b1) begin err_cnt++; $display("FAIL push_latency: got %b want 1", out_valid_a); end
      drive_a(1, 4'h2, 0);
      drive_a(1, 4'h3, 0);
      vec_cnt++; if (count_a !== 4'd3)       begin err_cnt++; $display("FAIL three_count: got %0d want 3", count_a); end
      vec_cnt++; if (out_valid_a !== 1'b1)   begin err_cnt++; $display("FAIL three_valid: got %b want 1", out_valid_a); end
      vec_cnt++; if (out_data_a !== 4'h1)    begin err_cnt++; $display("FAIL three_head: got %h want 1", out_data_a); end
      vec_cnt++; if (almost_full_a !== 1'b0) begin err_cnt++; $display("FAIL three_afull: got %b want 0", almost_full_a); end
   endtask

   task automatic test_fill_drop();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive_a(1, 4'(i), 0);
         vec_cnt++;
         if (almost_full_a !== ((i + 1) >= 6))
            begin err_cnt++; $display("FAIL fill_afull at count %0d: got %b want %b", i + 1, almost_full_a, (i + 1) >= 6); end
      end
      for (int i = 0; i < 3; i++) drive_a(1, 4'hF, 0);
      vec_cnt++; if (count_a !== 4'd8)       begin err_cnt++; $display("FAIL full_count: got %0d want 8", count_a); end
      vec_cnt++; if (in_ready_a !== 1'b0)    begin err_cnt++; $display("FAIL full_in_ready: got %b want 0", in_ready_a); end
      vec_cnt++; if (almost_full_a !== 1'b1) begin err_cnt++; $display("FAIL full_afull: got %b want 1", almost_full_a); end
      vec_cnt++; if (drop_cnt_a !== 4'd3)    begin err_cnt++; $display("FAIL drop_three: got %0d want 3", drop_cnt_a); end
      vec_cnt++; if (out_data_a !== 4'h0)    begin err_cnt++; $display("FAIL full_head: got %h want 0", out_data_a); end
      for (int i = 0; i < 15; i++) drive_a(1, 4'hF, 0);
      vec_cnt++; if (drop_cnt_a !== 4'd15)   begin err_cnt++; $display("FAIL drop_saturate: got %0d want 15", drop_cnt_a); end
   endtask

   // Continues from the full FIFO holding 0..7 left by test_fill_drop.
   task automatic test_wrap();
      obs_a.delete(); exp_a.delete();
      in_valid_a = 1; out_ready_a = 1;
      #1;
      vec_cnt++; if (in_ready_a !== 1'b0) begin err_cnt++; $display("FAIL ready_indep_of_pop: got %b want 0", in_ready_a); end
      for (int i = 0; i < 20; i++) begin
         drive_a(1, 4'($urandom), 1);
         vec_cnt++;
         if (count_a !== 4'(mq_a.size()))
            begin err_cnt++; $display("FAIL wrap_count cycle %0d: got %0d want %0d", i, count_a, mq_a.size()); end
      end
      for (int i = 0; i < 8; i++) begin
         vec_cnt++;
         if (obs_a.size() <= i || obs_a[i] !== 4'(i))
            begin err_cnt++; $display("FAIL wrap_initial_order %0d: got %h want %h", i, (obs_a.size() > i) ? obs_a[i] : 4'hx, 4'(i)); end
      end
      vec_cnt++; if (obs_a.size() !== exp_a.size()) begin err_cnt++; $display("FAIL wrap_pop_count: got %0d want %0d", obs_a.size(), exp_a.size()); end
      for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
         vec_cnt++; if (obs_a[i] !== exp_a[i]) begin err_cnt++; $display("FAIL wrap_data %0d: got %h want %h", i, obs_a[i], exp_a[i]); end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 4; i++) drive_a(1, 4'($urandom), 0);
      for (int i = 0; i < 10; i++) begin
         drive_a(1, 4'($urandom), 1);
         vec_cnt++; if (count_a !== 4'd4) begin err_cnt++; $display("FAIL b2b_count cycle %0d: got %0d want 4", i, count_a); end
      end
      vec_cnt++; if (obs_a.size() !== 10) begin err_cnt++; $display("FAIL b2b_pop_count: got %0d want 10", obs_a.size()); end
      for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
         vec_cnt++; if (obs_a[i] !== exp_a[i]) begin err_cnt++; $display("FAIL b2b_data %0d: got %h want %h", i, obs_a[i], exp_a[i]); end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 300; i++) begin
         // First half biased toward filling, second half toward draining.
         drive_a(($urandom_range(0, 9) < 7), 4'($urandom),
                 (i < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
         vec_cnt++; if (count_a !== 4'(mq_a.size()))
            begin err_cnt++; $display("FAIL rand_count cycle %0d: got %0d want %0d", i, count_a, mq_a.size()); end
         vec_cnt++; if (out_valid_a !== (mq_a.size() > 0) || in_ready_a !== (mq_a.size() < 8))
            begin err_cnt++; $display("FAIL rand_flags cycle %0d: got v=%b r=%b want v=%b r=%b", i, out_valid_a, in_ready_a, mq_a.size() > 0, mq_a.size() < 8); end
         vec_cnt++; if (almost_full_a !== (mq_a.size() >= 6))
            begin err_cnt++; $display("FAIL rand_afull cycle %0d: got %b want %b", i, almost_full_a, mq_a.size() >= 6); end
         vec_cnt++; if (drop_cnt_a !== 4'(drops_a))
            begin err_cnt++; $display("FAIL rand_drop cycle %0d: got %0d want %0d", i, drop_cnt_a, drops_a); end
         if (mq_a.size() > 0) begin
            vec_cnt++; if (out_data_a !== mq_a[0])
               begin err_cnt++; $display("FAIL rand_head cycle %0d: got %h want %h", i, out_data_a, mq_a[0]); end
         end
      end
      vec_cnt++; if (obs_a.size() !== exp_a.size()) begin err_cnt++; $display("FAIL rand_pop_count: got %0d want %0d", obs_a.size(), exp_a.size()); end
      for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
         vec_cnt++; if (obs_a[i] !== exp_a[i]) begin err_cnt++; $display("FAIL rand_data %0d: got %h want %h", i, obs_a[i], exp_a[i]); end
      end
   endtask

   task automatic test_override();
      do_reset();
      drive_b(1, 8'hA5, 0);
      vec_cnt++; if (out_valid_b !== 1'b1 || out_data_b !== 8'hA5)
         begin err_cnt++; $display("FAIL ovr_head: got v=%b d=%h want v=1 d=a5", out_valid_b, out_data_b); end
      for (int i = 0; i < 3; i++) begin
         drive_b(1, 8'($urandom), 0);
         vec_cnt++; if (almost_full_b !== (mq_b.size() >= 3))
            begin err_cnt++; $display("FAIL ovr_afull at count %0d: got %b want %b", mq_b.size(), almost_full_b, mq_b.size() >= 3); end
      end
      vec_cnt++; if (count_b !== 3'd4)    begin err_cnt++; $display("FAIL ovr_full_count: got %0d want 4", count_b); end
      vec_cnt++; if (in_ready_b !== 1'b0) begin err_cnt++; $display("FAIL ovr_full_ready: got %b want 0", in_ready_b); end
      for (int i = 0; i < 5; i++) drive_b(1, 8'hFF, 0);
      vec_cnt++; if (drop_cnt_b !== 2'd3) begin err_cnt++; $display("FAIL ovr_drop_sat: got %0d want 3", drop_cnt_b); end
      for (int i = 0; i < 4; i++) drive_b(0, 8'h00, 1);
      vec_cnt++; if (obs_b.size() < 1 || obs_b[0] !== 8'hA5)
         begin err_cnt++; $display("FAIL ovr_roundtrip: got %h want a5", (obs_b.size() > 0) ? obs_b[0] : 8'hxx); end
      vec_cnt++; if (obs_b.size() !== exp_b.size()) begin err_cnt++; $display("FAIL ovr_pop_count: got %0d want %0d", obs_b.size(), exp_b.size()); end
      for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
         vec_cnt++; if (obs_b[i] !== exp_b[i]) begin err_cnt++; $display("FAIL ovr_data %0d: got %h want %h", i, obs_b[i], exp_b[i]); end
      end
      vec_cnt++; if (count_b !== 3'd0 || out_valid_b !== 1'b0)
         begin err_cnt++; $display("FAIL ovr_drained: got count=%0d v=%b want 0 0", count_b, out_valid_b); end
   endtask

   task automatic test_async_reset();
      logic [3:0] x;
      do_reset();
      for (int i = 0; i < 8; i++) drive_a(1, 4'(i + 3), 0);
      for (int i = 0; i < 2; i++) drive_a(1, 4'hE, 0);
      for (int i = 0; i < 3; i++) drive_a(0, 4'h0, 1);
      vec_cnt++; if (count_a !== 4'd5 || drop_cnt_a !== 4'd2)
         begin err_cnt++; $display("FAIL pre_reset: got count=%0d drop=%0d want 5 2", count_a, drop_cnt_a); end
      #2;
      rst_n = 0;
      #1;
      vec_cnt++; if (count_a !== 4'd0 || drop_cnt_a !== 4'd0)
         begin err_cnt++; $display("FAIL async_rst_cnt: got count=%0d drop=%0d want 0 0", count_a, drop_cnt_a); end
      vec_cnt++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || almost_full_a !== 1'b0)
         begin err_cnt++; $display("FAIL async_rst_flags: got v=%b r=%b af=%b want 0 1 0", out_valid_a, in_ready_a, almost_full_a); end
      @(negedge clk);
      rst_n = 1;
      clear_model();
      x = 4'($urandom);
      drive_a(1, x, 0);
      vec_cnt++; if (count_a !== 4'd1 || out_valid_a !== 1'b1 || out_data_a !== x)
         begin err_cnt++; $display("FAIL post_rst_push: got count=%0d v=%b d=%h want 1 1 %h", count_a, out_valid_a, out_data_a, x); end
      drive_a(0, 4'h0, 1);
      vec_cnt++; if (count_a !== 4'd0 || out_valid_a !== 1'b0)
         begin err_cnt++; $display("FAIL post_rst_residue: got count=%0d v=%b want 0 0", count_a, out_valid_a); end
   endtask

   initial begin
      rst_n = 1;
      in_valid_a = 0; in_data_a = 0; out_ready_a = 0;
      in_valid_b = 0; in_data_b = 0; out_ready_b = 0;
      drops_a = 0; drops_b = 0;
      #1;
      test_reset();
      test_three_push();
      test_fill_drop();
      test_wrap();
      test_back_to_back();
      test_random();
      test_override();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
